// File: rtl/nfc_page_copy.sv
// nfc_page_copy: copies PAGES pages of NAND flash A to flash B through a one-page buffer; NFC_VERIFY_EN adds a read-back verify pass.
// Latency: 4*PAGE_BYTES + 4*ROW_CYCLES + 2*BUSY_GUARD + 11 clocks per page plus flash busy time; done rises one clock after the last NEXT.
// Backpressure: after each busy-inducing command, waits BUSY_GUARD clocks, then stalls until that device's RB reads high.
module nfc_page_copy #(
  parameter int PAGE_BYTES = 512,
  parameter int PAGES      = 512,
  parameter int ROW_CYCLES = 2,
  parameter int BUSY_GUARD = 4
) (
  input  logic       clk,
  input  logic       rst,
  output logic       done,
  inout  wire  [7:0] F_IO_A,
  output logic       F_CLE_A,
  output logic       F_ALE_A,
  output logic       F_REN_A,
  output logic       F_WEN_A,
  input  logic       F_RB_A,
  inout  wire  [7:0] F_IO_B,
  output logic       F_CLE_B,
  output logic       F_ALE_B,
  output logic       F_REN_B,
  output logic       F_WEN_B,
  input  logic       F_RB_B
`ifdef NFC_VERIFY_EN
  ,
  output logic [15:0] err_cnt
`endif
);

  localparam int CW   = $clog2(PAGE_BYTES) + 1;
  localparam int BW   = CW - 1;
  localparam int PW   = (PAGES > 1) ? $clog2(PAGES) : 1;
  localparam int SMAX = (ROW_CYCLES + 1 > BUSY_GUARD) ? ROW_CYCLES + 1 : BUSY_GUARD;
  localparam int SW   = $clog2(SMAX + 1);

  typedef enum logic [3:0] {
    IDLE, A_CMD, A_ADDR, A_WAIT, A_READ,
    B_CMD80, B_ADDR, B_DATA, B_CMD10, B_WAIT,
`ifdef NFC_VERIFY_EN
    V_CMD, V_ADDR, V_WAIT, V_READ,
`endif
    NEXT, DONE
  } state_t;

  state_t                  state, state_nx;
  logic                    ph, ph_nx;
  logic [SW-1:0]           step, step_nx;
  logic [CW-1:0]           col, col_nx;
  logic [PW-1:0]           page, page_nx;
  logic [7:0]              page_buf [PAGE_BYTES];
  logic                    buf_we;
  logic [7:0]              addr_byte;
  logic [8*ROW_CYCLES-1:0] row_ext;
  logic                    oe_a, oe_b;
  logic [7:0]              dout_a, dout_b;
  logic                    guard_done;
  wire  [BW-1:0]           idx = col[BW-1:0];
`ifdef NFC_VERIFY_EN
  logic                    vcmp;
`endif

  assign F_IO_A     = oe_a ? dout_a : 8'hzz;
  assign F_IO_B     = oe_b ? dout_b : 8'hzz;
  assign guard_done = (int'(step) + 1 >= BUSY_GUARD);

  // Column byte first, then the page index LSB byte first, zero-extended.
  always_comb begin
    row_ext   = (8*ROW_CYCLES)'(page);
    addr_byte = 8'h00;
    for (int k = 0; k < ROW_CYCLES; k++)
      if (int'(step) == k + 1) addr_byte = row_ext[8*k +: 8];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ph    <= 1'b0;
      step  <= '0;
      col   <= '0;
      page  <= '0;
    end else begin
      state <= state_nx;
      ph    <= ph_nx;
      step  <= step_nx;
      col   <= col_nx;
      page  <= page_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && buf_we) page_buf[idx] <= F_IO_A;
  end

`ifdef NFC_VERIFY_EN
  always_ff @(posedge clk) begin
    if (rst) err_cnt <= '0;
    else if (vcmp && F_IO_B != page_buf[idx] && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
  end
`endif

  // ph=0 is the strobe-low clock of a bus slot, ph=1 the strobe-high clock.
  always_comb begin
    state_nx = state;
    ph_nx    = 1'b0;
    step_nx  = step;
    col_nx   = col;
    page_nx  = page;
    buf_we   = 1'b0;
    done     = 1'b0;
    F_CLE_A  = 1'b0;
    F_ALE_A  = 1'b0;
    F_REN_A  = 1'b1;
    F_WEN_A  = 1'b1;
    oe_a     = 1'b0;
    dout_a   = 8'h00;
    F_CLE_B  = 1'b0;
    F_ALE_B  = 1'b0;
    F_REN_B  = 1'b1;
    F_WEN_B  = 1'b1;
    oe_b     = 1'b0;
    dout_b   = 8'h00;
`ifdef NFC_VERIFY_EN
    vcmp     = 1'b0;
`endif
    unique case (state)
      IDLE: state_nx = A_CMD;
      A_CMD: begin
        F_CLE_A = 1'b1; oe_a = 1'b1; dout_a = 8'h00; F_WEN_A = ph; ph_nx = ~ph;
        if (ph) begin state_nx = A_ADDR; step_nx = '0; end
      end
      A_ADDR: begin
        F_ALE_A = 1'b1; oe_a = 1'b1; dout_a = addr_byte; F_WEN_A = ph; ph_nx = ~ph;
        if (ph) begin
          step_nx = step + 1'b1;
          if (step == SW'(ROW_CYCLES)) begin state_nx = A_WAIT; step_nx = '0; end
        end
      end
      A_WAIT: begin
        if (!guard_done) step_nx = step + 1'b1;
        else if (F_RB_A) begin state_nx = A_READ; col_nx = '0; end
      end
      A_READ: begin
        // Byte is captured on the edge where REn returns high.
        F_REN_A = ph; ph_nx = ~ph; buf_we = ~ph;
        if (ph) begin
          col_nx = col + 1'b1;
          if (col_nx == CW'(PAGE_BYTES)) state_nx = B_CMD80;
        end
      end
      B_CMD80: begin
        F_CLE_B = 1'b1; oe_b = 1'b1; dout_b = 8'h80; F_WEN_B = ph; ph_nx = ~ph;
        if (ph) begin state_nx = B_ADDR; step_nx = '0; end
      end
      B_ADDR: begin
        F_ALE_B = 1'b1; oe_b = 1'b1; dout_b = addr_byte; F_WEN_B = ph; ph_nx = ~ph;
        if (ph) begin
          step_nx = step + 1'b1;
          if (step == SW'(ROW_CYCLES)) begin state_nx = B_DATA; col_nx = '0; end
        end
      end
      B_DATA: begin
        oe_b = 1'b1; dout_b = page_buf[idx]; F_WEN_B = ph; ph_nx = ~ph;
        if (ph) begin
          col_nx = col + 1'b1;
          if (col_nx == CW'(PAGE_BYTES)) state_nx = B_CMD10;
        end
      end
      B_CMD10: begin
        F_CLE_B = 1'b1; oe_b = 1'b1; dout_b = 8'h10; F_WEN_B = ph; ph_nx = ~ph;
        if (ph) begin state_nx = B_WAIT; step_nx = '0; end
      end
      B_WAIT: begin
        if (!guard_done) step_nx = step + 1'b1;
`ifdef NFC_VERIFY_EN
        else if (F_RB_B) state_nx = V_CMD;
      end
      V_CMD: begin
        F_CLE_B = 1'b1; oe_b = 1'b1; dout_b = 8'h00; F_WEN_B = ph; ph_nx = ~ph;
        if (ph) begin state_nx = V_ADDR; step_nx = '0; end
      end
      V_ADDR: begin
        F_ALE_B = 1'b1; oe_b = 1'b1; dout_b = addr_byte; F_WEN_B = ph; ph_nx = ~ph;
        if (ph) begin
          step_nx = step + 1'b1;
          if (step == SW'(ROW_CYCLES)) begin state_nx = V_WAIT; step_nx = '0; end
        end
      end
      V_WAIT: begin
        if (!guard_done) step_nx = step + 1'b1;
        else if (F_RB_B) begin state_nx = V_READ; col_nx = '0; end
      end
      V_READ: begin
        F_REN_B = ph; ph_nx = ~ph; vcmp = ~ph;
        if (ph) begin
          col_nx = col + 1'b1;
          if (col_nx == CW'(PAGE_BYTES)) state_nx = NEXT;
        end
      end
`else
        else if (F_RB_B) state_nx = NEXT;
      end
`endif
      NEXT: begin
        page_nx  = page + 1'b1;
        state_nx = (page == PW'(PAGES - 1)) ? DONE : A_CMD;
      end
      DONE: done = 1'b1;
      default: state_nx = IDLE;
    endcase
  end

endmodule
